// File: rtl/xaui_rx_idle_strip_if.sv
// Column-level bus between lane deskew and the XGMII-side MAC for the XAUI
// receive idle stripper, plus the qualified remote link-status outputs.
interface xaui_rx_idle_strip_if;
  logic [31:0] rxdata_i;
  logic [3:0]  rxcharisk_i;
  logic        rxvalid_i;
  logic [31:0] rxdata_o;
  logic [3:0]  rxcharisk_o;
  logic        in_frame;
  logic [31:0] link_status;
  logic        link_status_event;
  logic        q_err;

  modport master (
    output rxdata_i, rxcharisk_i, rxvalid_i,
    input  rxdata_o, rxcharisk_o, in_frame, link_status, link_status_event, q_err
  );

  modport slave (
    input  rxdata_i, rxcharisk_i, rxvalid_i,
    output rxdata_o, rxcharisk_o, in_frame, link_status, link_status_event, q_err
  );
endinterface

// File: rtl/xaui_rx_idle_strip.sv
// XAUI receive idle stripper: maps /K/ /R/ /A/ back to XGMII idle, removes
// ||Q|| columns in the IFG and debounces their payload into link_status.
module xaui_rx_idle_strip #(
  parameter int unsigned Q_MATCH = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  xaui_rx_idle_strip_if.slave  bus
);

  localparam logic [7:0]  CODE_K   = 8'hBC;
  localparam logic [7:0]  CODE_R   = 8'h1C;
  localparam logic [7:0]  CODE_A   = 8'h7C;
  localparam logic [7:0]  CODE_Q   = 8'h9C;
  localparam logic [7:0]  CODE_S   = 8'hFB;
  localparam logic [7:0]  CODE_T   = 8'hFD;
  localparam logic [7:0]  CODE_I   = 8'h07;
  localparam logic [31:0] IDLE_COL = {4{CODE_I}};
  localparam logic [3:0]  Q_MAX    = 4'(Q_MATCH);

  typedef enum logic {IFG, FRAME} state_t;

  state_t      state_q, state_d;
  logic [31:0] cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ls_q, ls_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  isk_q, isk_d;
  logic        in_frame_q, in_frame_d;
  logic        event_q, event_d;
  logic        q_err_q, q_err_d;

  logic [31:0] conv_data;
  logic [7:0]  lane_byte;
  logic        has_t, start_lane0, is_q;

  // Per-lane idle conversion and /T/ search, independent of the FSM.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    conv_data = bus.rxdata_i;
    has_t     = 1'b0;
    lane_byte = 8'h00;
    for (int l = 0; l < 4; l++) begin
      lane_byte = bus.rxdata_i[8*l +: 8];
      if (bus.rxcharisk_i[l] &&
          (lane_byte == CODE_K || lane_byte == CODE_R || lane_byte == CODE_A))
        conv_data[8*l +: 8] = CODE_I;
      if (bus.rxcharisk_i[l] && lane_byte == CODE_T)
        has_t = 1'b1;
    end
    start_lane0 = bus.rxcharisk_i[0] && (bus.rxdata_i[7:0] == CODE_S);
    is_q        = (bus.rxcharisk_i == 4'b0001) && (bus.rxdata_i[7:0] == CODE_Q);
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    ls_d       = ls_q;
    data_d     = IDLE_COL;
    isk_d      = 4'hF;
    in_frame_d = 1'b0;
    event_d    = 1'b0;
    q_err_d    = 1'b0;

    if (!bus.rxvalid_i) begin
      state_d = IFG;
      cnt_d   = 4'd0;
    end else if (is_q && state_q == IFG) begin
      if (bus.rxdata_i == cand_q) begin
        cnt_d = (cnt_q >= Q_MAX) ? Q_MAX : cnt_q + 4'd1;
      end else begin
        cand_d = bus.rxdata_i;
        cnt_d  = 4'd1;
      end
      if (cnt_d == Q_MAX && cand_d != ls_q) begin
        ls_d    = cand_d;
        event_d = 1'b1;
      end
    end else if (is_q) begin
      // ||Q|| inside a frame is data corruption: forward it untouched and flag.
      data_d     = bus.rxdata_i;
      isk_d      = bus.rxcharisk_i;
      in_frame_d = 1'b1;
      q_err_d    = 1'b1;
    end else begin
      data_d = conv_data;
      isk_d  = bus.rxcharisk_i;
      // /S/ in lane0 wins over any /T/ later in the same column.
      if (start_lane0)
        state_d = FRAME;
      else if (state_q == FRAME && has_t)
        state_d = IFG;
      in_frame_d = (state_q == FRAME) || start_lane0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IFG;
      cand_q     <= 32'h0;
      cnt_q      <= 4'd0;
      ls_q       <= 32'h0;
      data_q     <= IDLE_COL;
      isk_q      <= 4'hF;
      in_frame_q <= 1'b0;
      event_q    <= 1'b0;
      q_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      ls_q       <= ls_d;
      data_q     <= data_d;
      isk_q      <= isk_d;
      in_frame_q <= in_frame_d;
      event_q    <= event_d;
      q_err_q    <= q_err_d;
    end
  end

  assign bus.rxdata_o          = data_q;
  assign bus.rxcharisk_o       = isk_q;
  assign bus.in_frame          = in_frame_q;
  assign bus.link_status       = ls_q;
  assign bus.link_status_event = event_q;
  assign bus.q_err             = q_err_q;

endmodule

// File: tb/tb_xaui_rx_idle_strip.sv
// Directed bench for xaui_rx_idle_strip: each step queues its expected output
// column, which is popped and compared one clock later.
module tb_xaui_rx_idle_strip;

  localparam logic [31:0] IDLE = 32'h07070707;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  isk;
    logic        in_frame;
    logic [31:0] ls;
    logic        ev;
    logic        qerr;
  } obs_t;

  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t exp_q[$];

  xaui_rx_idle_strip_if bus ();

  xaui_rx_idle_strip #(.Q_MATCH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(logic [31:0] d, logic [3:0] k, logic inf,
                              logic [31:0] ls, logic ev, logic qe);
    obs_t o;
    o.data = d; o.isk = k; o.in_frame = inf; o.ls = ls; o.ev = ev; o.qerr = qe;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.rxdata_o, bus.rxcharisk_o, bus.in_frame,
              bus.link_status, bus.link_status_event, bus.q_err);
  endfunction

  task automatic check(string tag, obs_t obs, obs_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(string tag, logic [31:0] d, logic [3:0] k, logic v, obs_t e);
    bus.rxdata_i    = d;
    bus.rxcharisk_i = k;
    bus.rxvalid_i   = v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag, sample(), exp_q.pop_front());
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.rxdata_i    = 32'h0;
    bus.rxcharisk_i = 4'h0;
    bus.rxvalid_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", sample(), mk(IDLE, 4'hF, 0, 32'h0, 0, 0));
    reset_n = 1'b1;

    // Idle ordered sets
    step("idle_A", 32'h7C7C7C7C, 4'hF, 1, mk(IDLE, 4'hF, 0, 32'h0, 0, 0));
    step("idle_K", 32'hBCBCBCBC, 4'hF, 1, mk(IDLE, 4'hF, 0, 32'h0, 0, 0));
    step("idle_R", 32'h1C1C1C1C, 4'hF, 1, mk(IDLE, 4'hF, 0, 32'h0, 0, 0));
    step("mixed_lanes", 32'h1C7CBC07, 4'b0111, 1, mk(32'h1C070707, 4'b0111, 0, 32'h0, 0, 0));

    // Qualification of a repeated ||Q||
    step("q1_first",  32'h0100009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0, 0, 0));
    step("q1_second", 32'h0100009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0100009C, 1, 0));
    step("q1_third",  32'h0100009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0100009C, 0, 0));

    // Alternating payloads never qualify; a repeat afterwards does
    step("q4_a", 32'h0400009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0100009C, 0, 0));
    step("q5",   32'h0500009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0100009C, 0, 0));
    step("q4_b", 32'h0400009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0100009C, 0, 0));
    step("q4_c", 32'h0400009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0400009C, 1, 0));

    // Frame containing a ||Q|| column
    step("frm_S",    32'h555555FB, 4'b0001, 1, mk(32'h555555FB, 4'b0001, 1, 32'h0400009C, 0, 0));
    step("frm_data", 32'h44332211, 4'b0000, 1, mk(32'h44332211, 4'b0000, 1, 32'h0400009C, 0, 0));
    step("frm_Q",    32'h0300009C, 4'b0001, 1, mk(32'h0300009C, 4'b0001, 1, 32'h0400009C, 0, 1));
    step("frm_T",    32'hBCBCBCFD, 4'hF,    1, mk(32'h070707FD, 4'hF,    1, 32'h0400009C, 0, 0));
    step("post_T",   32'hBCBCBCBC, 4'hF,    1, mk(IDLE, 4'hF, 0, 32'h0400009C, 0, 0));
    // In-frame ||Q|| must not have touched the candidate
    step("q3_ifg",   32'h0300009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0400009C, 0, 0));
    step("q4_ifg",   32'h0400009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0400009C, 0, 0));

    // S in lane0 with T in lane3 stays in frame
    step("st_col",   32'hFD5555FB, 4'b1001, 1, mk(32'hFD5555FB, 4'b1001, 1, 32'h0400009C, 0, 0));
    step("st_data",  32'h11111111, 4'b0000, 1, mk(32'h11111111, 4'b0000, 1, 32'h0400009C, 0, 0));
    step("st_T2",    32'h07FDAA99, 4'b0100, 1, mk(32'h07FDAA99, 4'b0100, 1, 32'h0400009C, 0, 0));
    step("st_after", 32'hBCBCBCBC, 4'hF,    1, mk(IDLE, 4'hF, 0, 32'h0400009C, 0, 0));

    // Loss of rxvalid_i between two matching ||Q|| columns
    step("q6_a",     32'h0600009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0400009C, 0, 0));
    step("q6_drop",  32'h0600009C, 4'b0001, 0, mk(IDLE, 4'hF, 0, 32'h0400009C, 0, 0));
    step("q6_b",     32'h0600009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0400009C, 0, 0));
    step("q6_c",     32'h0600009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0600009C, 1, 0));

    // Loss of rxvalid_i mid-frame returns to IFG
    step("v_S",      32'h555555FB, 4'b0001, 1, mk(32'h555555FB, 4'b0001, 1, 32'h0600009C, 0, 0));
    step("v_drop",   32'h44332211, 4'b0000, 0, mk(IDLE, 4'hF, 0, 32'h0600009C, 0, 0));
    step("v_data",   32'h12345678, 4'b0000, 1, mk(32'h12345678, 4'b0000, 0, 32'h0600009C, 0, 0));

    // Asynchronous reset mid-frame
    step("r_S",      32'h555555FB, 4'b0001, 1, mk(32'h555555FB, 4'b0001, 1, 32'h0600009C, 0, 0));
    bus.rxdata_i    = 32'h22222222;
    bus.rxcharisk_i = 4'b0000;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", sample(), mk(IDLE, 4'hF, 0, 32'h0, 0, 0));
    @(posedge clk);
    #1;
    check("reset_hold", sample(), mk(IDLE, 4'hF, 0, 32'h0, 0, 0));
    reset_n = 1'b1;
    step("r_q1_a",   32'h0100009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0, 0, 0));
    step("r_q1_b",   32'h0100009C, 4'b0001, 1, mk(IDLE, 4'hF, 0, 32'h0100009C, 1, 0));
    step("r_data",   32'h33333333, 4'b0000, 1, mk(32'h33333333, 4'b0000, 0, 32'h0100009C, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xaui_rx_idle_strip.md
Name: xaui_rx_idle_strip

Overview:
- Receive-side counterpart of the XAUI transmit idle generator.
- Sits after lane deskew, before the XGMII-side MAC interface; one 32-bit column per clock, lane0 in [7:0].
- Converts received idle ordered sets (/K/, /R/, /A/) back to XGMII idle (0x07).
- Strips ||Q|| sequence columns from the stream and qualifies their payload into a debounced remote link_status word with a one-cycle event strobe.

Parameters:
- Q_MATCH, 2: consecutive identical ||Q|| columns needed before link_status updates; legal 1..15.

Ports:
- clk  input  1  column clock.
- reset_n  input  1  asynchronous active-low reset.
- rxdata_i  input  32  deskewed received column.
- rxcharisk_i  input  4  per-lane K flag for rxdata_i.
- rxvalid_i  input  1  lanes synced and aligned; column is meaningful.
- rxdata_o  output  32  XGMII-side column.
- rxcharisk_o  output  4  XGMII-side control flags.
- in_frame  output  1  current column lies between /S/ and /T/.
- link_status  output  32  last qualified ||Q|| column, raw, lane0 = 0x9C.
- link_status_event  output  1  one-cycle pulse when link_status changes.
- q_err  output  1  one-cycle pulse: ||Q|| column received inside a frame.

Behaviour:
- Codes: K=0xBC, R=0x1C, A=0x7C, Q=0x9C, S=0xFB, T=0xFD, I=0x07.
- All outputs are registered; latency is exactly 1 clock from rxdata_i to rxdata_o.
- Reset (async, reset_n=0):
  - rxdata_o=0x07070707, rxcharisk_o=4'hF.
  - link_status=0, link_status_event=0, q_err=0, in_frame=0.
  - Internal state IFG; q_cand=0; q_cnt=0.
- Q column definition: rxcharisk_i==4'b0001 and rxdata_i[7:0]==0x9C.
- Per-lane idle conversion, every non-Q column, either state:
  - A lane with isk=1 and byte in {K,R,A} outputs 0x07, isk=1.
  - All other lanes pass unchanged.
  - Example: a T column "T K K K" outputs "T I I I".
- State machine, advanced only when rxvalid_i=1:
  - IFG -> FRAME when rxcharisk_i[0]=1 and rxdata_i[7:0]==S.
  - FRAME -> IFG when any lane has isk=1 and byte==T.
  - in_frame is registered with the column: it is 1 for the output S column through the T column inclusive, 0 otherwise.
- Q column received in IFG:
  - Output 0x07070707, isk 4'hF.
  - If payload==q_cand: q_cnt increments, saturating at Q_MATCH.
  - Otherwise: q_cand <= payload, q_cnt <= 1.
  - Qualification: when the post-update q_cnt reaches Q_MATCH and q_cand != link_status, link_status <= q_cand in the same clock as the output column and link_status_event=1 for that cycle.
  - While saturated, further identical Q columns produce no event.
- Q column received in FRAME:
  - Passed through unchanged.
  - q_err=1 for one cycle.
  - q_cand and q_cnt unchanged.
- q_cand and q_cnt persist across frames and idle columns; only a differing Q column or loss of rxvalid_i resets the count.
- rxvalid_i=0:
  - Output 0x07070707 / 4'hF.
  - State forced to IFG; q_cnt=0.
  - link_status holds its value; no event and no q_err pulse.
- Simultaneous-event priority: rxvalid_i low > Q detection > S/T state change.
- A column holding S in lane0 and T in a later lane stays in FRAME; the T is ignored.

Test Plan:
- Reset release, rxvalid_i=1, columns A,A,A,A then K,K,K,K then R,R,R,R, isk 4'hF -> rxdata_o=0x07070707, isk 4'hF from cycle 2; link_status=0; no event.
- Q_MATCH=2, idles then Q 0x0100009C, Q 0x0100009C -> single event one cycle after the second Q; link_status=0x0100009C; both Q outputs idle. A third identical Q -> no event.
- Q 0x0100009C, then Q 0x0200009C, then Q 0x0100009C -> no event; q_cnt never reaches 2.
- Frame S,data,Q(0x0300009C),T K K K -> Q column passes through unchanged; q_err pulses once; in_frame=1 on S through T; T column outputs 0x070707FD with isk 4'hF.
- Two matching Q columns with rxvalid_i dropped for one cycle between them -> no event; the idle output 0x07070707 appears on the dropped cycle.
- Assert reset_n=0 mid-frame after link_status=0x0100009C -> all outputs return to reset values asynchronously; after release, Q-qualification restarts from q_cnt=0.
